// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-only data memory, with read-modify-write for sub-word stores.
// Define MISALIGN_TRAP_EN to answer misaligned requests with rsp_err instead of accessing memory.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       data_q, data_d;

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  lo,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        unique case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'b00:   load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    // Only the addressed lane(s) take store data; the rest keep the read word.
    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [31:0] d,
        input logic [1:0]  sz,
        input logic [1:0]  lo
    );
        logic [31:0] m;
        m = w;
        unique case (sz)
            2'b00: begin
                unique case (lo)
                    2'd0:    m[7:0]   = d[7:0];
                    2'd1:    m[15:8]  = d[7:0];
                    2'd2:    m[23:16] = d[7:0];
                    default: m[31:24] = d[7:0];
                endcase
            end
            2'b01: begin
                if (lo[1]) m[31:16] = d[15:0];
                else       m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        merge = m;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic req_mis;

    assign req_mis = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size[1] && req_addr[1:0] != 2'b00);
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = rdy_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign mem_ren   = (state_q == S_RD);
    assign mem_wen   = (state_q == S_WR);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_din   = din_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        din_d   = din_q;
        data_d  = data_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && rdy_q) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    data_d  = '0;
`ifdef MISALIGN_TRAP_EN
                    err_d   = 1'b0;
                    if (req_mis) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else
`endif
                    if (!req_we) begin
                        state_d = S_RD;
                    end else if (req_size[1]) begin
                        state_d = S_WR;
                        din_d   = req_wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (!we_q) begin
                    data_d  = load_ext(mem_dout, size_q, addr_q[1:0], uns_q);
                    state_d = S_RESP;
                end else begin
                    din_d   = merge(mem_dout, wdata_q, size_q, addr_q[1:0]);
                    state_d = S_WR;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            default: begin
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            data_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            data_q  <= data_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Random and directed load/store traffic against a word-array reference of memory.
// Memory model writes on the negedge of a mem_wen cycle.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [1024] = '{default: 32'h0};
    logic [31:0] ref_mem [1024];
    int n_chk = 0;
    int n_fail = 0;
    int both_hi = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_dout = mem[mem_addr[11:2]];

    always @(negedge clock) begin
        if (reset && mem_wen && !mem_ren) mem[mem_addr[11:2]] <= mem_din;
        if (mem_ren && mem_wen) both_hi <= both_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input int stall,
                          output logic [31:0] d, output logic e,
                          output int lat, output int nren, output int nwen);
        int g;
        @(negedge clock);
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 1);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nren = 0; nwen = 0;
        do begin
            @(negedge clock);
            lat++;
            nren += int'(mem_ren);
            nwen += int'(mem_wen);
            if (mem_ren || mem_wen)
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
        end while (!rsp_valid && lat < 10);
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        lat = lat - 1;
        d = rsp_data;
        e = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_valid", {31'b0, rsp_valid}, 1);
            check("stall_data", rsp_data, d);
            check("stall_ready", {31'b0, req_ready}, 0);
            check("stall_mem", {30'b0, mem_ren, mem_wen}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int stall, output logic [31:0] d, output logic e);
        logic [31:0] w, v, mask;
        int sh, xl, xr, xw;
        logic mis, trap, ee;
        int lat, nr, nw;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`endif
        w = ref_mem[a[11:2]];
        v = 32'h0; ee = 1'b0;
        if (trap) begin
            ee = 1'b1; xl = 0; xr = 0; xw = 0;
        end else if (!we) begin
            xl = 1; xr = 1; xw = 0;
            if (sz == 2'd0) begin
                sh = 8 * int'(a[1:0]);
                v = (w >> sh) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                sh = a[1] ? 16 : 0;
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
        end else if (sz >= 2'd2) begin
            xl = 1; xr = 0; xw = 1;
            w = wd;
        end else begin
            xl = 2; xr = 1; xw = 1;
            sh = (sz == 2'd0) ? 8 * int'(a[1:0]) : (a[1] ? 16 : 0);
            mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            w = (w & ~mask) | ((wd << sh) & mask);
        end
        ref_mem[a[11:2]] = w;
        do_req(we, sz, uns, a, wd, stall, d, e, lat, nr, nw);
        check("rsp_data", d, v);
        check("rsp_err", {31'b0, e}, {31'b0, ee});
        check("latency", 32'(lat), 32'(xl));
        check("ren_cycles", 32'(nr), 32'(xr));
        check("wen_cycles", 32'(nw), 32'(xw));
    endtask

    logic [31:0] d;
    logic        e;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_size = 2'b0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_ready", {31'b0, req_ready}, 0);
        check("rst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
        check("rst_mem", {30'b0, mem_ren, mem_wen}, 0);
        check("rst_addr", mem_addr, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_rst", {31'b0, req_ready}, 1);

        run(1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 0, d, e);
        run(0, 2'd2, 0, 32'h40, 32'h0, 0, d, e);
        check("lw_deadbeef", d, 32'hDEADBEEF);
        run(1, 2'd2, 0, 32'h40, 32'h11223344, 0, d, e);
        run(1, 2'd0, 0, 32'h41, 32'h000000AA, 0, d, e);
        run(0, 2'd2, 0, 32'h40, 32'h0, 0, d, e);
        check("sb_merge", d, 32'h1122AA44);
        run(1, 2'd2, 0, 32'h40, 32'h80FF7F01, 0, d, e);
        run(0, 2'd0, 0, 32'h42, 32'h0, 0, d, e);
        check("lb_sext", d, 32'hFFFFFFFF);
        run(0, 2'd0, 1, 32'h42, 32'h0, 0, d, e);
        check("lbu_zext", d, 32'h000000FF);
        run(0, 2'd1, 0, 32'h42, 32'h0, 5, d, e);
        check("lh_sext", d, 32'hFFFF80FF);
        run(0, 2'd1, 0, 32'h43, 32'h0, 0, d, e);
`ifdef MISALIGN_TRAP_EN
        check("lh_mis_data", d, 32'h0);
        check("lh_mis_err", {31'b0, e}, 1);
`else
        check("lh_mis_data", d, 32'hFFFF80FF);
        check("lh_mis_err", {31'b0, e}, 0);
`endif

        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("mid_rd_ren", {31'b0, mem_ren}, 1);
        reset = 1'b0;
        #1;
        check("arst_ready", {31'b0, req_ready}, 0);
        check("arst_rsp", {30'b0, rsp_valid, rsp_err}, 0);
        check("arst_mem", {30'b0, mem_ren, mem_wen}, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_din", mem_din, 0);
        check("arst_data", rsp_data, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rerst_ready", {31'b0, req_ready}, 1);
        repeat (3) begin
            @(negedge clock);
            check("rerst_no_rsp", {31'b0, rsp_valid}, 0);
        end

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            run(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
                $urandom_range(0, 2), d, e);
        end
        for (int i = 0; i < 32; i++) check("mem_final", mem[i], ref_mem[i]);
        check("ren_wen_excl", 32'(both_hi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
